// File: rtl/servo_pkg.sv
// Shared constants and arithmetic helpers for the two-channel servo controller.
package servo_pkg;

    localparam logic [7:0] SPEED_STOP = 8'd128;
    localparam logic [2:0] STEP_ZERO  = 3'd4;

    // Apply a signed per-frame offset (step - 4, range -4..+3) and clamp to 0..255.
    function automatic logic [7:0] sat_step(input logic [7:0] spd, input logic [2:0] step);
        int sum;
        sum = int'(spd) + int'(step) - int'(STEP_ZERO);
        if (sum < 0)
            return 8'd0;
        else if (sum > 255)
            return 8'd255;
        else
            return sum[7:0];
    endfunction

    // Pulse width in microseconds; speed 256 would map to max_us, so 255 lands just below it.
    function automatic int speed_to_width(input logic [7:0] spd, input int min_us, input int max_us);
        return min_us + ((int'(spd) * (max_us - min_us)) >> 8);
    endfunction

    // Reflect a speed around stop for a wheel mounted the other way round; 0 maps to 255.
    function automatic logic [7:0] mirror_speed(input logic [7:0] spd);
        return (spd == 8'd0) ? 8'd255 : 8'(9'd256 - {1'b0, spd});
    endfunction

endpackage

// File: rtl/servo_pwm.sv
// One servo channel: speed register, per-frame adjust, frame-latched width and PWM flop.
module servo_pwm
    import servo_pkg::*;
#(
    parameter int FW           = 15,
    parameter int PULSE_MIN_US = 1000,
    parameter int PULSE_MAX_US = 2000,
    parameter bit MIRROR       = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          frame_start,
    input  logic [FW-1:0] frame_cnt,
    input  logic          speed_write_en,
    input  logic [7:0]    speed,
    input  logic [2:0]    step,
    output logic          pwm_out
);

    localparam logic [FW-1:0] WIDTH_STOP = FW'(speed_to_width(SPEED_STOP, PULSE_MIN_US, PULSE_MAX_US));

    logic [7:0]    speed_q;
    logic [7:0]    speed_d;
    logic [7:0]    pwm_speed;
    logic [FW-1:0] width_q;
    logic [FW-1:0] width_d;
    logic          pwm_q;

    // Next speed: direct load wins every cycle; otherwise nudge once per frame.
    always_comb begin
        speed_d = speed_q;
        if (speed_write_en)
            speed_d = speed;
        else if (frame_start)
            speed_d = sat_step(speed_q, step);
    end

    // Width is sampled only at frame start, from the speed being written on that same edge.
    always_comb begin
        pwm_speed = MIRROR ? mirror_speed(speed_d) : speed_d;
        width_d   = width_q;
        if (frame_start)
            width_d = FW'(speed_to_width(pwm_speed, PULSE_MIN_US, PULSE_MAX_US));
    end

    // Speed/width registers and the output flop; output only moves on microsecond ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_q <= SPEED_STOP;
            width_q <= WIDTH_STOP;
            pwm_q   <= 1'b0;
        end else begin
            speed_q <= speed_d;
            width_q <= width_d;
            if (tick)
                pwm_q <= (frame_cnt < width_d);
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/servo_pair_control.sv
// Two-channel continuous-rotation servo controller: shared microsecond prescaler and
// frame counter feeding one servo_pwm per wheel.
// Build option: define SERVO1_MIRROR_EN to drive channel 1 from the mirrored speed.
module servo_pair_control
    import servo_pkg::*;
#(
    parameter int CLK_HZ       = 12_000_000,
    parameter int FRAME_US     = 20000,
    parameter int PULSE_MIN_US = 1000,
    parameter int PULSE_MAX_US = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       servo_0_speed_write_en,
    input  logic       servo_1_speed_write_en,
    input  logic [7:0] servo_0_speed,
    input  logic [7:0] servo_1_speed,
    input  logic [2:0] servo_0_step,
    input  logic [2:0] servo_1_step,
    output logic       PWM_OUT_0,
    output logic       PWM_OUT_1
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW  = $clog2(FRAME_US);

`ifdef SERVO1_MIRROR_EN
    localparam bit MIRROR_1 = 1'b1;
`else
    localparam bit MIRROR_1 = 1'b0;
`endif

    logic [PW-1:0] pre_q;
    logic [FW-1:0] frame_q;
    logic          tick;
    logic          frame_start;

    assign tick        = (pre_q == PW'(DIV - 1));
    assign frame_start = tick && (frame_q == '0);

    // Microsecond prescaler; with a 1 MHz clock it is pinned at zero and ticks every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre_q <= '0;
        else if (tick)
            pre_q <= '0;
        else
            pre_q <= pre_q + PW'(1);
    end

    // Frame counter in microseconds, wrapping at the PWM period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_q <= '0;
        else if (tick)
            frame_q <= (frame_q == FW'(FRAME_US - 1)) ? '0 : frame_q + FW'(1);
    end

    servo_pwm #(
        .FW           (FW),
        .PULSE_MIN_US (PULSE_MIN_US),
        .PULSE_MAX_US (PULSE_MAX_US),
        .MIRROR       (1'b0)
    ) u_ch0 (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick           (tick),
        .frame_start    (frame_start),
        .frame_cnt      (frame_q),
        .speed_write_en (servo_0_speed_write_en),
        .speed          (servo_0_speed),
        .step           (servo_0_step),
        .pwm_out        (PWM_OUT_0)
    );

    servo_pwm #(
        .FW           (FW),
        .PULSE_MIN_US (PULSE_MIN_US),
        .PULSE_MAX_US (PULSE_MAX_US),
        .MIRROR       (MIRROR_1)
    ) u_ch1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick           (tick),
        .frame_start    (frame_start),
        .frame_cnt      (frame_q),
        .speed_write_en (servo_1_speed_write_en),
        .speed          (servo_1_speed),
        .step           (servo_1_step),
        .pwm_out        (PWM_OUT_1)
    );

endmodule

// File: tb/tb_servo_pair_control.sv
// Self-checking bench for servo_pair_control at 1 MHz with a shortened 2000 us frame.
module tb_servo_pair_control;

    localparam int FRAME = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wen0 = 1'b1, wen1 = 1'b1;
    logic [7:0] spd0 = 8'd128, spd1 = 8'd128;
    logic [2:0] st0 = 3'd4, st1 = 3'd4;
    logic       pwm0, pwm1;

    int total = 0;
    int bad   = 0;
    int m_spd0 = 128;
    int m_spd1 = 128;

    servo_pair_control #(
        .CLK_HZ       (1_000_000),
        .FRAME_US     (FRAME),
        .PULSE_MIN_US (1000),
        .PULSE_MAX_US (2000)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .servo_0_speed_write_en (wen0),
        .servo_1_speed_write_en (wen1),
        .servo_0_speed          (spd0),
        .servo_1_speed          (spd1),
        .servo_0_step           (st0),
        .servo_1_step           (st1),
        .PWM_OUT_0              (pwm0),
        .PWM_OUT_1              (pwm1)
    );

    always #5 clk = ~clk;

    function automatic int ref_width(input int s);
        return 1000 + (s * 1000) / 256;
    endfunction

    function automatic int ref_width1(input int s);
`ifdef SERVO1_MIRROR_EN
        return ref_width((s == 0) ? 255 : 256 - s);
`else
        return ref_width(s);
`endif
    endfunction

    function automatic int clamp255(input int s);
        return (s < 0) ? 0 : ((s > 255) ? 255 : s);
    endfunction

    // Model one frame start, then measure the pulse widths of that frame in clocks.
    task automatic run_frame(input int chg_at, input logic [7:0] chg_val,
                             output int e0, output int e1, output int w0, output int w1,
                             output int per, output bit found);
        bit prev;
        m_spd0 = wen0 ? int'(spd0) : clamp255(m_spd0 + int'(st0) - 4);
        m_spd1 = wen1 ? int'(spd1) : clamp255(m_spd1 + int'(st1) - 4);
        e0 = ref_width(m_spd0);
        e1 = ref_width1(m_spd1);
        found = 1'b0;
        per = 0;
        w0 = 0;
        w1 = 0;
        prev = pwm0;
        for (int i = 0; i < FRAME + 10 && !found; i++) begin
            @(negedge clk);
            if (pwm0 && !prev) begin
                found = 1'b1;
                per = FRAME - 1 + (i + 1);
            end
            prev = pwm0;
        end
        if (!found) return;
        w0 = int'(pwm0);
        w1 = int'(pwm1);
        for (int i = 1; i < FRAME; i++) begin
            if (i == chg_at) spd0 = chg_val;
            @(negedge clk);
            w0 += int'(pwm0);
            w1 += int'(pwm1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (pwm0 !== 1'b0) begin bad++; $display("FAIL reset_pwm0: got %b want 0", pwm0); end
        total++;
        if (pwm1 !== 1'b0) begin bad++; $display("FAIL reset_pwm1: got %b want 0", pwm1); end
        m_spd0 = 128;
        m_spd1 = 128;
        rst_n = 1'b1;
    endtask

    task automatic test_stop();
        int e0, e1, w0, w1, per;
        bit f;
        wen0 = 1'b1; wen1 = 1'b1; spd0 = 8'd128; spd1 = 8'd128;
        run_frame(-1, 8'd0, e0, e1, w0, w1, per, f);
        total++;
        if (!f || w0 !== 1500) begin bad++; $display("FAIL stop_ch0: got %0d want 1500 found=%0d", w0, f); end
        total++;
        if (!f || w1 !== 1500) begin bad++; $display("FAIL stop_ch1: got %0d want 1500 found=%0d", w1, f); end
        run_frame(-1, 8'd0, e0, e1, w0, w1, per, f);
        total++;
        if (!f || per !== FRAME) begin bad++; $display("FAIL stop_period: got %0d want %0d", per, FRAME); end
        total++;
        if (!f || w0 !== e0 || w1 !== e1) begin
            bad++; $display("FAIL stop_frame2: got %0d/%0d want %0d/%0d", w0, w1, e0, e1);
        end
    endtask

    task automatic test_load();
        int e0, e1, w0, w1, per;
        bit f;
        wen0 = 1'b1; spd0 = 8'd140; wen1 = 1'b1; spd1 = 8'd116;
        run_frame(-1, 8'd0, e0, e1, w0, w1, per, f);
        total++;
        if (!f || w0 !== 1546) begin bad++; $display("FAIL load_ch0: got %0d want 1546", w0); end
        total++;
        if (!f || w1 !== e1) begin bad++; $display("FAIL load_ch1: got %0d want %0d", w1, e1); end
    endtask

    task automatic test_glitch();
        int e0, e1, w0, w1, per;
        bit f;
        wen0 = 1'b1; spd0 = 8'd0;
        run_frame(500, 8'd255, e0, e1, w0, w1, per, f);
        total++;
        if (!f || w0 !== 1000) begin bad++; $display("FAIL glitch_hold: got %0d want 1000", w0); end
        run_frame(-1, 8'd0, e0, e1, w0, w1, per, f);
        total++;
        if (!f || w0 !== 1996) begin bad++; $display("FAIL glitch_next: got %0d want 1996", w0); end
    endtask

    task automatic test_sat_up();
        int e0, e1, w0, w1, per;
        bit f;
        wen0 = 1'b1; spd0 = 8'd250;
        run_frame(-1, 8'd0, e0, e1, w0, w1, per, f);
        total++;
        if (!f || w0 !== e0) begin bad++; $display("FAIL satup_load: got %0d want %0d", w0, e0); end
        wen0 = 1'b0; st0 = 3'd7;
        for (int k = 0; k < 3; k++) begin
            run_frame(-1, 8'd0, e0, e1, w0, w1, per, f);
            total++;
            if (!f || w0 !== e0) begin bad++; $display("FAIL satup_frame%0d: got %0d want %0d", k, w0, e0); end
        end
        total++;
        if (w0 !== 1996) begin bad++; $display("FAIL satup_clamp: got %0d want 1996", w0); end
    endtask

    task automatic test_sat_down();
        int e0, e1, w0, w1, per;
        bit f;
        wen1 = 1'b1; spd1 = 8'd2;
        run_frame(-1, 8'd0, e0, e1, w0, w1, per, f);
        total++;
        if (!f || w1 !== e1) begin bad++; $display("FAIL satdn_load: got %0d want %0d", w1, e1); end
        wen1 = 1'b0; st1 = 3'd0;
        for (int k = 0; k < 2; k++) begin
            run_frame(-1, 8'd0, e0, e1, w0, w1, per, f);
            total++;
            if (!f || w1 !== e1) begin bad++; $display("FAIL satdn_frame%0d: got %0d want %0d", k, w1, e1); end
        end
        st1 = 3'd4;
        wen0 = 1'b1; spd0 = 8'd90;
        for (int k = 0; k < 2; k++) begin
            run_frame(-1, 8'd0, e0, e1, w0, w1, per, f);
            total++;
            if (!f || w1 !== e1 || w0 !== e0) begin
                bad++; $display("FAIL hold_frame%0d: got %0d/%0d want %0d/%0d", k, w0, w1, e0, e1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int e0, e1, w0, w1, per;
        bit f;
        bit prev;
        wen0 = 1'b1; spd0 = 8'd200; wen1 = 1'b1; spd1 = 8'd30;
        f = 1'b0;
        prev = pwm0;
        for (int i = 0; i < FRAME + 10 && !f; i++) begin
            @(negedge clk);
            if (pwm0 && !prev) f = 1'b1;
            prev = pwm0;
        end
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (!f || pwm0 !== 1'b0 || pwm1 !== 1'b0) begin
            bad++; $display("FAIL rstmid_low: got %b%b want 00 found=%0d", pwm0, pwm1, f);
        end
        wen0 = 1'b0; wen1 = 1'b0; st0 = 3'd4; st1 = 3'd4;
        repeat (5) @(negedge clk);
        m_spd0 = 128;
        m_spd1 = 128;
        rst_n = 1'b1;
        run_frame(-1, 8'd0, e0, e1, w0, w1, per, f);
        total++;
        if (!f || w0 !== 1500 || w1 !== 1500) begin
            bad++; $display("FAIL rstmid_speed: got %0d/%0d want 1500/1500", w0, w1);
        end
    endtask

    task automatic test_random();
        int e0, e1, w0, w1, per;
        bit f;
        for (int k = 0; k < 8; k++) begin
            wen0 = 1'($urandom_range(0, 1));
            wen1 = 1'($urandom_range(0, 1));
            spd0 = 8'($urandom_range(0, 255));
            spd1 = 8'($urandom_range(0, 255));
            st0  = 3'($urandom_range(0, 7));
            st1  = 3'($urandom_range(0, 7));
            run_frame(-1, 8'd0, e0, e1, w0, w1, per, f);
            total++;
            if (!f || w0 !== e0 || w1 !== e1) begin
                bad++; $display("FAIL random%0d: got %0d/%0d want %0d/%0d", k, w0, w1, e0, e1);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stop();
        test_load();
        test_glitch();
        test_sat_up();
        test_sat_down();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
